// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory access controller:
// access size, FSM state, load extension and store lane helpers.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [1:0] SIZE_RSVD = 2'd3;
    localparam int         CNT_W     = 16;

    function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
        logic signed [7:0]  sb;
        logic signed [31:0] sw;
        sb = signed'(b);
        sw = 32'(sb);
        return sgn ? unsigned'(sw) : {24'd0, b};
    endfunction

    function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
        logic signed [15:0] sh;
        logic signed [31:0] sw;
        sh = signed'(h);
        sw = 32'(sh);
        return sgn ? unsigned'(sw) : {16'd0, h};
    endfunction

    function automatic logic [3:0] byte_en(input mem_size_t sz, input logic [1:0] off);
        logic [3:0] be;
        case (sz)
            MEM_B:   be = 4'b0001 << off;
            MEM_H:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the low byte/half across all lanes so the memory picks by mem_be.
    function automatic logic [31:0] lane_data(input mem_size_t sz, input logic [31:0] wd);
        logic [31:0] d;
        case (sz)
            MEM_B:   d = {4{wd[7:0]}};
            MEM_H:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load aligner: shifts the addressed lane down and
// sign- or zero-extends byte and half results.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [1:0]        offset,
    input  mem_size_t         size,
    input  logic              is_signed,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = mem_rdata >> {offset, 3'b000};
        case (size)
            MEM_B:   result = ext_byte(shifted[7:0], is_signed);
            MEM_H:   result = ext_half(shifted[15:0], is_signed);
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences core loads/stores onto a req/ready data-memory port, stalling
// the core while the access is outstanding and flagging faults/timeouts.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [1:0]        MemReadSize,
    input  logic              MemReadSigned,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              access_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    mem_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    mem_size_t         size_p1;
    logic              signed_p1;
    logic [1:0]        off_p1;
    logic              misaligned;
    logic              legal;
    logic              illegal;
    logic              timeout_hit;
    logic [DATA_W-1:0] load_res;

    // Request decode from the control unit (only acted on in IDLE)
    always_comb begin
        misaligned = ((MemReadSize == MEM_H) && addr[0]) ||
                     ((MemReadSize == MEM_W) && (addr[1:0] != 2'b00));
        legal      = (MemRead ^ MemWrite) && (MemReadSize != SIZE_RSVD) && !misaligned;
        illegal    = (MemRead | MemWrite) && !legal;
    end

    assign timeout_hit = (state == WAIT) && !mem_ready && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (legal) begin
                    stall     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem_ready || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage p1: access captured in IDLE, presented on the port through WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            rdata        <= '0;
            access_fault <= 1'b0;
            cnt          <= '0;
            size_p1      <= MEM_B;
            signed_p1    <= 1'b0;
            off_p1       <= 2'b00;
        end else begin
            access_fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (legal) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWrite;
                        mem_addr  <= {addr[DATA_W-1:2], 2'b00};
                        mem_be    <= byte_en(mem_size_t'(MemReadSize), addr[1:0]);
                        mem_wdata <= lane_data(mem_size_t'(MemReadSize), wdata);
                        size_p1   <= mem_size_t'(MemReadSize);
                        signed_p1 <= MemReadSigned;
                        off_p1    <= addr[1:0];
                        cnt       <= '0;
                    end else if (illegal) begin
                        access_fault <= 1'b1;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata <= load_res;
                        end
                    end else if (timeout_hit) begin
                        mem_req      <= 1'b0;
                        access_fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    load_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .mem_rdata(mem_rdata),
        .offset   (off_p1),
        .size     (size_p1),
        .is_signed(signed_p1),
        .result   (load_res)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized accesses
// against a byte-level reference model of the memory access rules.
module tb_mem_access_ctrl;

    localparam int TO_A = 8;
    localparam int TO_B = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead, MemWrite, MemReadSigned;
    logic [1:0]  MemReadSize;
    logic [31:0] addr, wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        a_stall, a_fault, a_req, a_we;
    logic [31:0] a_rdata, a_maddr, a_mwdata;
    logic [3:0]  a_be;
    logic        b_stall, b_fault, b_req, b_we;
    logic [31:0] b_rdata, b_maddr, b_mwdata;
    logic [3:0]  b_be;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYC(TO_A), .DATA_W(32)) dut_a (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemReadSize(MemReadSize), .MemReadSigned(MemReadSigned),
        .addr(addr), .wdata(wdata), .stall(a_stall), .rdata(a_rdata),
        .access_fault(a_fault), .mem_req(a_req), .mem_we(a_we),
        .mem_addr(a_maddr), .mem_be(a_be), .mem_wdata(a_mwdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    mem_access_ctrl #(.TIMEOUT_CYC(TO_B), .DATA_W(32)) dut_b (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemReadSize(MemReadSize), .MemReadSigned(MemReadSigned),
        .addr(addr), .wdata(wdata), .stall(b_stall), .rdata(b_rdata),
        .access_fault(b_fault), .mem_req(b_req), .mem_we(b_we),
        .mem_addr(b_maddr), .mem_be(b_be), .mem_wdata(b_mwdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    bit          use_b = 1'b0;
    logic        o_stall, o_fault, o_req, o_we;
    logic [31:0] o_rdata, o_addr, o_wdata;
    logic [3:0]  o_be;

    always_comb begin
        o_stall = use_b ? b_stall  : a_stall;
        o_fault = use_b ? b_fault  : a_fault;
        o_req   = use_b ? b_req    : a_req;
        o_we    = use_b ? b_we     : a_we;
        o_rdata = use_b ? b_rdata  : a_rdata;
        o_addr  = use_b ? b_maddr  : a_maddr;
        o_wdata = use_b ? b_mwdata : a_mwdata;
        o_be    = use_b ? b_be     : a_be;
    end

    int nvec = 0;
    int nmis = 0;
    logic [31:0] model_rdata = 32'd0;

    // Observations of one instruction, filled by do_access
    int          obs_stall, obs_req, obs_fault, obs_fault_at;
    bit          obs_unstable, obs_hung;
    logic [31:0] obs_addr, obs_wdata, obs_rdata;
    logic [3:0]  obs_be;
    logic        obs_we;

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] a);
        int nb;
        if (rd == wr || sz == 2'd3) return 1'b0;
        nb = 1 << sz;
        return (a % nb) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be;
        int off, nb;
        nb  = 1 << sz;
        off = (nb == 4) ? 0 : int'(a % 4);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nb);
        return be;
    endfunction

    function automatic logic [31:0] ref_lanes(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] d;
        int nb;
        nb = 1 << sz;
        for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % nb) +: 8];
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [31:0] a, input logic sgn);
        longint v;
        int nb, off;
        nb  = 1 << sz;
        off = int'(a % 4);
        v   = (longint'(word) >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
        if (sgn && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    // ---------------- driver / observer ----------------
    // Presents one instruction, holds it while stall is high (and for the
    // retiring cycle), answers mem_req with ready on WAIT cycle 'delay'
    // (0 = never), then idles two cycles.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] a, input logic [31:0] wd, input int delay,
                             input logic [31:0] rword);
        int widx, rel_at;
        bit prev_stall, prev_req, seen_req;
        obs_stall = 0; obs_req = 0; obs_fault = 0; obs_fault_at = -1;
        obs_unstable = 1'b0; obs_hung = 1'b1; obs_rdata = o_rdata;
        obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0;
        widx = 0; rel_at = -1; prev_stall = 1'b1; prev_req = 1'b0; seen_req = 1'b0;
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; MemReadSize = sz; MemReadSigned = sgn; addr = a; wdata = wd;
        for (int c = 0; c < 100; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c > 0 && rel_at < 0 && !prev_stall) begin
                MemRead = 1'b0; MemWrite = 1'b0; rel_at = c;
            end
            if (o_req) begin
                widx++;
                mem_ready = (widx == delay);
            end else begin
                mem_ready = 1'b0;
            end
            mem_rdata = mem_ready ? rword : $urandom;
            #3;
            if (o_stall) obs_stall++;
            if (o_fault) begin
                obs_fault++;
                if (obs_fault_at < 0) obs_fault_at = c;
            end
            if (o_req) begin
                if (!seen_req) begin
                    obs_addr = o_addr; obs_be = o_be; obs_wdata = o_wdata; obs_we = o_we;
                end else if (o_addr !== obs_addr || o_be !== obs_be || o_wdata !== obs_wdata || o_we !== obs_we) begin
                    obs_unstable = 1'b1;
                end
                seen_req = 1'b1;
                obs_req++;
            end else if (prev_req) begin
                obs_rdata = o_rdata;
            end
            prev_req = o_req; prev_stall = o_stall;
            if (rel_at >= 0 && c == rel_at + 2) begin
                obs_hung = 1'b0;
                break;
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_rdata = 32'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; MemReadSize = 2'd0; MemReadSigned = 1'b0;
        addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #4;
        nvec++;
        if ({a_req, a_we, a_fault, a_stall} !== 4'b0000) begin
            nmis++; $display("FAIL reset_ctrl: got req/we/fault/stall=%b required 0000", {a_req, a_we, a_fault, a_stall});
        end
        nvec++;
        if (a_maddr !== 32'd0 || a_be !== 4'd0 || a_mwdata !== 32'd0 || a_rdata !== 32'd0) begin
            nmis++; $display("FAIL reset_data: got addr=%h be=%b wdata=%h rdata=%h required all zero", a_maddr, a_be, a_mwdata, a_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #3;
        nvec++;
        if (a_stall !== 1'b0 || a_req !== 1'b0) begin
            nmis++; $display("FAIL reset_idle: got stall=%b req=%b required 0 0", a_stall, a_req);
        end
    endtask

    task automatic test_lb_signed();
        do_access(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234);
        model_rdata = 32'hFFFF_FF80;
        nvec++;
        if (obs_hung || obs_addr !== 32'h0000_1000 || obs_be !== 4'b1000 || obs_we !== 1'b0) begin
            nmis++; $display("FAIL lb_port: got addr=%h be=%b we=%b hung=%0d required 00001000 1000 0 0", obs_addr, obs_be, obs_we, obs_hung);
        end
        nvec++;
        if (obs_stall !== 2 || obs_req !== 1) begin
            nmis++; $display("FAIL lb_timing: got stall=%0d req=%0d required 2 1", obs_stall, obs_req);
        end
        nvec++;
        if (obs_rdata !== 32'hFFFF_FF80 || obs_fault !== 0) begin
            nmis++; $display("FAIL lb_rdata: got %h fault=%0d required ffffff80 0", obs_rdata, obs_fault);
        end
    endtask

    task automatic test_lhu_slow();
        do_access(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 5, 32'h9ABC_0000);
        model_rdata = 32'h0000_9ABC;
        nvec++;
        if (obs_hung || obs_be !== 4'b1100 || obs_req !== 5 || obs_unstable) begin
            nmis++; $display("FAIL lhu_port: got be=%b req=%0d unstable=%0d required 1100 5 0", obs_be, obs_req, obs_unstable);
        end
        nvec++;
        if (obs_stall !== 6 || obs_rdata !== 32'h0000_9ABC) begin
            nmis++; $display("FAIL lhu_result: got stall=%0d rdata=%h required 6 00009abc", obs_stall, obs_rdata);
        end
    endtask

    task automatic test_sb();
        do_access(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h1234_56A5, 1, 32'hDEAD_BEEF);
        nvec++;
        if (obs_we !== 1'b1 || obs_be !== 4'b0010 || obs_wdata !== 32'hA5A5_A5A5 || obs_addr !== 32'h0000_3000) begin
            nmis++; $display("FAIL sb_port: got we=%b be=%b wdata=%h addr=%h required 1 0010 a5a5a5a5 00003000", obs_we, obs_be, obs_wdata, obs_addr);
        end
        nvec++;
        if (obs_rdata !== model_rdata || obs_stall !== 2) begin
            nmis++; $display("FAIL sb_rdata: got rdata=%h stall=%0d required %h 2", obs_rdata, obs_stall, model_rdata);
        end
    endtask

    task automatic test_illegal();
        logic [1:0] szs [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        logic [31:0] ads [4] = '{32'h4002, 32'h4001, 32'h4000, 32'h4000};
        logic        wrs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            do_access((k != 1), wrs[k], szs[k], 1'b0, ads[k], 32'h5555_AAAA, 1, 32'h0);
            nvec++;
            if (obs_hung || obs_fault !== 1 || obs_fault_at !== 1 || obs_req !== 0 || obs_stall !== 0) begin
                nmis++; $display("FAIL illegal_%0d: got fault=%0d at=%0d req=%0d stall=%0d required 1 1 0 0", k, obs_fault, obs_fault_at, obs_req, obs_stall);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nst, nrq;
        nst = 0; nrq = 0;
        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b0; MemReadSize = 2'd2; MemReadSigned = 1'b1;
        addr = 32'h0000_5000; mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            #3;
            if (a_stall) nst++;
            if (a_req) nrq++;
        end
        @(posedge clk); #1;
        MemRead = 1'b0; mem_ready = 1'b0;
        model_rdata = 32'hCAFE_F00D;
        #3;
        nvec++;
        if (nst !== 6 || nrq !== 3 || a_rdata !== 32'hCAFE_F00D) begin
            nmis++; $display("FAIL back_to_back: got stall=%0d req=%0d rdata=%h required 6 3 cafef00d", nst, nrq, a_rdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic rd, wr, sgn, lg, req_any, to;
            logic [1:0] sz;
            logic [31:0] a, wd, rw;
            int dly, nreq, sel;
            sel = $urandom_range(0, 9);
            rd = (sel == 0) || (sel >= 2 && sel <= 5);
            wr = (sel == 0) || (sel >= 6);
            sz = 2'($urandom_range(0, 3));
            sgn = 1'($urandom);
            a = $urandom; wd = $urandom; rw = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd2) a[1:0] = 2'b00;
                if (sz == 2'd1) a[0] = 1'b0;
            end
            dly = $urandom_range(0, 10);
            do_access(rd, wr, sz, sgn, a, wd, dly, rw);
            req_any = rd | wr;
            lg = ref_legal(rd, wr, sz, a);
            to = lg && (dly == 0 || dly > TO_A);
            nreq = !lg ? 0 : (to ? TO_A : dly);
            if (lg && rd && !to) model_rdata = ref_load(rw, sz, a, sgn);
            nvec++;
            if (obs_hung || obs_req !== nreq || obs_stall !== (lg ? nreq + 1 : 0)) begin
                nmis++; $display("FAIL rand_%0d_timing: got req=%0d stall=%0d hung=%0d required %0d %0d 0", n, obs_req, obs_stall, obs_hung, nreq, lg ? nreq + 1 : 0);
            end
            nvec++;
            if (obs_fault !== ((req_any && (!lg || to)) ? 1 : 0)) begin
                nmis++; $display("FAIL rand_%0d_fault: got %0d required %0d", n, obs_fault, (req_any && (!lg || to)) ? 1 : 0);
            end
            if (lg) begin
                nvec++;
                if (obs_addr !== {a[31:2], 2'b00} || obs_be !== ref_be(sz, a) || obs_we !== wr || obs_unstable ||
                    (wr && obs_wdata !== ref_lanes(sz, wd))) begin
                    nmis++; $display("FAIL rand_%0d_port: got addr=%h be=%b we=%b wdata=%h unstable=%0d required %h %b %b %h 0",
                                     n, obs_addr, obs_be, obs_we, obs_wdata, obs_unstable, {a[31:2], 2'b00}, ref_be(sz, a), wr, ref_lanes(sz, wd));
                end
                nvec++;
                if (obs_rdata !== model_rdata) begin
                    nmis++; $display("FAIL rand_%0d_rdata: got %h required %h", n, obs_rdata, model_rdata);
                end
            end
        end
    endtask

    task automatic test_timeout();
        pulse_reset();
        use_b = 1'b1;
        do_access(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'h0, 0, 32'h0);
        use_b = 1'b0;
        nvec++;
        if (obs_hung || obs_req !== TO_B || obs_stall !== TO_B + 1) begin
            nmis++; $display("FAIL timeout_timing: got req=%0d stall=%0d required %0d %0d", obs_req, obs_stall, TO_B, TO_B + 1);
        end
        nvec++;
        if (obs_fault !== 1 || obs_fault_at !== TO_B + 1 || obs_rdata !== 32'd0) begin
            nmis++; $display("FAIL timeout_fault: got fault=%0d at=%0d rdata=%h required 1 %0d 0", obs_fault, obs_fault_at, obs_rdata, TO_B + 1);
        end
        pulse_reset();
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b0; MemReadSize = 2'd2; addr = 32'h0000_6000; mem_ready = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2;
        nvec++;
        if (a_req !== 1'b1) begin
            nmis++; $display("FAIL rstwait_pre: got req=%b required 1", a_req);
        end
        rst = 1'b1; MemRead = 1'b0;
        #1;
        nvec++;
        if (a_req !== 1'b0 || a_stall !== 1'b0) begin
            nmis++; $display("FAIL rstwait_async: got req=%b stall=%b required 0 0", a_req, a_stall);
        end
        model_rdata = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        #3;
        nvec++;
        if (a_rdata !== model_rdata || a_req !== 1'b0 || a_stall !== 1'b0) begin
            nmis++; $display("FAIL rstwait_late_ready: got rdata=%h req=%b stall=%b required %h 0 0", a_rdata, a_req, a_stall, model_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_lb_signed();
        test_lhu_slow();
        test_sb();
        test_illegal();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences every load and store from the core datapath onto a data-memory port with a req/ready handshake.
- Sits between the main control unit outputs (MemRead, MemWrite, MemReadSize, MemReadSigned), the ALU address and the data memory.
- Stalls the core while an access is outstanding.
- Generates byte enables and lane-replicated store data, aligns and extends load data, and flags misaligned, illegal and timed-out accesses.

Parameters:
- TIMEOUT_CYC, 255: maximum WAIT cycles before abort; range 1..65535.
- DATA_W, 32: data and address width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- MemRead  in  1  load requested (from control unit)
- MemWrite  in  1  store requested (from control unit)
- MemReadSize  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved; used for stores too (funct3[1:0])
- MemReadSigned  in  1  sign-extend load result
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC and pipeline registers
- rdata  out  32  aligned and extended load result
- access_fault  out  1  one-cycle fault pulse
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_ready  in  1  memory accepts or completes the request this cycle
- mem_rdata  in  32  read word, valid when mem_ready=1 and mem_we=0

Behaviour:
- Reset (async, immediate) values:
  - state=IDLE
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0
  - rdata=0, access_fault=0
  - timeout counter=0
  - stall=0
- FSM states: IDLE, WAIT, DONE.
- IDLE, legal access (exactly one of MemRead/MemWrite, size!=3, aligned):
  - stall=1 combinationally in the same cycle.
  - Register mem_addr, mem_be, mem_wdata and mem_we; capture size, signed flag and addr[1:0].
  - Next cycle: mem_req=1, state -> WAIT, counter=0.
- IDLE, illegal access:
  - Illegal means: MemRead and MemWrite both high; size==3; half with addr[0]=1; word with addr[1:0]!=0.
  - access_fault=1 on the next cycle, exactly one cycle.
  - No memory request and no stall; state stays IDLE.
- IDLE, no request: no action; stall=0.
- WAIT:
  - stall=1; mem_req stays 1 with addr/be/we/wdata held stable.
  - mem_ready=1 (including the first WAIT cycle): mem_req drops next cycle, state -> DONE. For a load, rdata is registered at that edge.
  - No mem_ready: counter increments. When counter reaches TIMEOUT_CYC-1 without ready, the next edge drops mem_req, pulses access_fault and moves to DONE. rdata is unchanged.
- DONE:
  - stall=0, so the pipeline advances this cycle.
  - MemRead/MemWrite are ignored this cycle because the same instruction is still present.
  - Next state is IDLE.
- Minimum latency: stall high for 2 cycles, with rdata valid in the DONE cycle. Back-to-back memory instructions therefore cost 3 cycles each.
- rdata holds its value until the next successful load completes.
- mem_be:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- mem_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Loads:
  - shifted = mem_rdata >> (8*addr[1:0]).
  - Byte: shifted[7:0], sign- or zero-extended per the signed flag.
  - Half: shifted[15:0], sign- or zero-extended per the signed flag.
  - Word: passed unchanged; the signed flag is ignored.
- For loads, mem_be is driven the same way as for stores.
- Reset asserted in WAIT: mem_req drops asynchronously. Any in-flight memory response is ignored after reset is released.

Decomposition:
- Shared package mem_pkg:
  - mem_size_t enum: MEM_B=0, MEM_H=1, MEM_W=2.
  - mem_state_t enum for IDLE, WAIT, DONE.
  - Sign/zero extension helper functions.
- Sub-module load_align (combinational): inputs mem_rdata, byte offset, size, signed; output 32-bit result.
- The FSM, counter and store-lane logic stay in mem_access_ctrl.

Test Plan:
- LB, signed, addr=0x1003, mem_rdata=0x80FF_1234 on the first WAIT cycle:
  - mem_addr=0x1000, mem_be=4'b1000
  - stall high for 2 cycles
  - rdata=0xFFFF_FF80 in DONE
- LHU, addr=0x2002, mem_rdata=0x9ABC_0000, ready after 5 WAIT cycles:
  - mem_be=4'b1100, mem_req held for 5 cycles
  - rdata=0x0000_9ABC
  - stall high for 6 cycles total
- SB, wdata=0x1234_56A5, addr=0x3001:
  - mem_we=1, mem_be=4'b0010, mem_wdata=0xA5A5_A5A5
  - rdata unchanged
- LW addr=0x4002; SH addr=0x4001; size=3; MemRead and MemWrite both high:
  - each pulses access_fault for 1 cycle
  - mem_req never asserts, stall stays 0
- TIMEOUT_CYC=4, mem_ready held 0:
  - mem_req high for 4 cycles, then access_fault pulses
  - DONE entered, stall released
- Reset mid-WAIT:
  - mem_req falls in the same cycle as rst rises (asynchronous)
  - state=IDLE; a late mem_ready after release causes no rdata update
